// File: rtl/pipe_pkg.sv
// Shared types and constants for the decoupled pipeline stage register.
// Optional stall counter is enabled by defining PIPE_STALL_CNT_EN.
package pipe_pkg;

  localparam int EXC_W_DEF = 5;

  localparam logic [EXC_W_DEF-1:0] EXC_NONE = '0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload+exception register with load, clear and masked flush.
// Flush keeps only the payload bits outside CLR_MASK.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int EXC_W  = EXC_W_DEF,
  parameter logic [DATA_W-1:0] CLR_MASK = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [EXC_W-1:0]  d_exc,
  output logic              v,
  output logic [DATA_W-1:0] data,
  output logic [EXC_W-1:0]  exc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      v    <= 1'b0;
      data <= '0;
      exc  <= '0;
    end else if (flush) begin
      v    <= 1'b0;
      data <= data & ~CLR_MASK;
      exc  <= '0;
    end else if (load) begin
      v    <= 1'b1;
      data <= d_data;
      exc  <= d_exc;
    end else if (clr) begin
      v    <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Decoupled stage register: valid/ready handshake with a 2-entry skid.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int EXC_W  = EXC_W_DEF,
  parameter logic [DATA_W-1:0] CLR_MASK = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [1:0]        occ
);

  logic              m_v, s_v;
  logic [DATA_W-1:0] s_data;
  logic [EXC_W-1:0]  s_exc;
  logic              accept, emit;
  logic              m_load, m_clr;
  logic              s_load, s_clr;
  logic [DATA_W-1:0] m_d;
  logic [EXC_W-1:0]  m_e;
  occ_e              occ_q;

  assign in_ready  = reset & ~s_v;
  assign accept    = in_valid & in_ready;
  assign emit      = m_v & out_ready;
  assign out_valid = m_v;

  // skid always holds the older beat, so it wins the refill of main
  assign m_load = (~m_v & accept) | (emit & (s_v | accept));
  assign m_clr  = emit & ~s_v & ~accept;
  assign m_d    = s_v ? s_data : in_data;
  assign m_e    = s_v ? s_exc : in_exc;

  assign s_load = m_v & ~emit & accept;
  assign s_clr  = emit & s_v;

  assign occ_q = s_v ? OCC_FULL : (m_v ? OCC_ONE : OCC_EMPTY);
  assign occ   = occ_q;

  pipe_slot #(
    .DATA_W  (DATA_W),
    .EXC_W   (EXC_W),
    .CLR_MASK(CLR_MASK)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .load  (m_load),
    .clr   (m_clr),
    .d_data(m_d),
    .d_exc (m_e),
    .v     (m_v),
    .data  (out_data),
    .exc   (out_exc)
  );

  pipe_slot #(
    .DATA_W  (DATA_W),
    .EXC_W   (EXC_W),
    .CLR_MASK(CLR_MASK)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .load  (s_load),
    .clr   (s_clr),
    .d_data(in_data),
    .d_exc (in_exc),
    .v     (s_v),
    .data  (s_data),
    .exc   (s_exc)
  );

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cnt <= '0;
    else if (m_v & ~out_ready & ~flush & ~(&stall_cnt))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: vector table, hand sequences,
// and random traffic against a queue model.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DW = 96;
  localparam int EW = 5;
  localparam logic [DW-1:0] MASK = 96'h0000_0000_FFFF_FFFF_0000_0000;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [EW-1:0] in_exc, out_exc;
  logic [1:0]    occ;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W(DW), .EXC_W(EW), .CLR_MASK(MASK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_exc   (in_exc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_exc  (out_exc),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .occ      (occ)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic [EW-1:0] ie;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [EW-1:0] ee;
    logic [1:0]    eo;
    logic          eir;
  } vec_t;

  function automatic vec_t mk(logic fl, logic iv, logic [DW-1:0] id,
                              logic [EW-1:0] ie, logic ordy, logic ev,
                              logic [DW-1:0] ed, logic [EW-1:0] ee,
                              logic [1:0] eo, logic eir);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ie = ie; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.ee = ee; v.eo = eo; v.eir = eir;
    return v;
  endfunction

  logic [DW-1:0] A, B, C, D;
  vec_t tv[13];
  logic [DW-1:0] q_d[$];
  logic [EW-1:0] q_e[$];

  initial begin
    A = 96'h1111_1111_2222_2222_3333_3333;
    B = 96'hBBBB_0000_BBBB_0000_BBBB_0001;
    C = 96'hCCCC_CCCC_DDDD_DDDD_EEEE_EEEE;
    D = 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    // reset held low with a beat offered
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_data = A; in_exc = 5'h0C;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", DW'(in_ready), '0);
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_occ", DW'(occ), '0);
    end
    chk("rst_out_data", out_data, '0);
    chk("rst_out_exc", DW'(out_exc), '0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_in_ready", DW'(in_ready), 1);
    step();
    chk("rel_occ", DW'(occ), 0);

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_exc = EW'(i);
      step();
      chk("str_valid", DW'(out_valid), 1);
      chk("str_data", out_data, DW'(i));
      chk("str_occ", DW'(occ), 1);
    end
    in_valid = 1'b0;
    step();
    chk("str_drain_occ", DW'(occ), 0);

    // backpressure, flush-while-full, flush+accept+emit
    tv[0]  = mk(0, 1, A, 5'h0C, 0, 1, A, 5'h0C, 1, 1);
    tv[1]  = mk(0, 1, B, 5'h01, 0, 1, A, 5'h0C, 2, 0);
    tv[2]  = mk(0, 1, C, 5'h02, 0, 1, A, 5'h0C, 2, 0);
    tv[3]  = mk(0, 1, C, 5'h02, 1, 1, B, 5'h01, 1, 1);
    tv[4]  = mk(0, 1, C, 5'h02, 1, 1, C, 5'h02, 1, 1);
    tv[5]  = mk(0, 0, D, 5'h03, 1, 0, C, 5'h02, 0, 1);
    tv[6]  = mk(0, 1, A, 5'h0C, 0, 1, A, 5'h0C, 1, 1);
    tv[7]  = mk(0, 1, B, 5'h01, 0, 1, A, 5'h0C, 2, 0);
    tv[8]  = mk(1, 1, D, 5'h03, 1, 0,
                96'h1111_1111_0000_0000_3333_3333, 5'h00, 0, 1);
    tv[9]  = mk(0, 0, D, 5'h03, 1, 0,
                96'h1111_1111_0000_0000_3333_3333, 5'h00, 0, 1);
    tv[10] = mk(0, 1, C, 5'h02, 0, 1, C, 5'h02, 1, 1);
    tv[11] = mk(1, 1, D, 5'h03, 1, 0, C & ~MASK, 5'h00, 0, 1);
    tv[12] = mk(0, 0, D, 5'h03, 1, 0, C & ~MASK, 5'h00, 0, 1);
    for (int i = 0; i < 13; i++) begin
      flush = tv[i].fl; in_valid = tv[i].iv; in_data = tv[i].id;
      in_exc = tv[i].ie; out_ready = tv[i].ordy;
      step();
      chk($sformatf("v%0d_valid", i), DW'(out_valid), DW'(tv[i].ev));
      chk($sformatf("v%0d_data", i), out_data, tv[i].ed);
      chk($sformatf("v%0d_exc", i), DW'(out_exc), DW'(tv[i].ee));
      chk($sformatf("v%0d_occ", i), DW'(occ), DW'(tv[i].eo));
      chk($sformatf("v%0d_in_ready", i), DW'(in_ready), DW'(tv[i].eir));
    end
    flush = 1'b0;

    // random traffic against a FIFO-of-depth-2 model
    for (int c = 0; c < 400; c++) begin
      logic acc;
      flush = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = {$urandom, $urandom, $urandom};
      in_exc = EW'($urandom);
      #1;
      chk("rnd_in_ready", DW'(in_ready), DW'(q_d.size() < 2));
      chk("rnd_occ", DW'(occ), DW'(q_d.size()));
      chk("rnd_valid", DW'(out_valid), DW'(q_d.size() > 0));
      if (q_d.size() > 0) begin
        chk("rnd_data", out_data, q_d[0]);
        chk("rnd_exc", DW'(out_exc), DW'(q_e[0]));
      end
      acc = in_valid && (q_d.size() < 2);
      if (flush) begin
        q_d.delete(); q_e.delete();
      end else begin
        if (out_ready && q_d.size() > 0) begin
          void'(q_d.pop_front()); void'(q_e.pop_front());
        end
        if (acc) begin
          q_d.push_back(in_data); q_e.push_back(in_exc);
        end
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;

`ifdef PIPE_STALL_CNT_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("stall_rst", DW'(stall_cnt), 0);
    in_valid = 1'b1; out_ready = 1'b0; in_data = A;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("stall_10", DW'(stall_cnt), 10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_flush", DW'(stall_cnt), 10);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("stall_clr", DW'(stall_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
